// File: rtl/debug_watch_scanner.sv
// rtl/debug_watch_scanner.sv - debug tick divider, watch index/address walker and display select
module debug_watch_scanner #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int REG_NUM_W  = 5,
   parameter int REG_COUNT  = 32,
   parameter int NUM_CH     = 4,
   parameter int DIV_W      = 32,
   parameter int TAP_FAST   = 24,
   parameter int TAP_SLOW   = 27,
   parameter int MEM_STRIDE = 4,
   parameter int MEM_LIMIT  = 256
) (
   input  logic                     clk,
   input  logic                     resetNeg,
   input  logic                     slow_sel,
   input  logic [1:0]               mode,
   input  logic                     step_btn,
   input  logic [NUM_CH-1:0]        ch_sel,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic                     tick,
   output logic [REG_NUM_W-1:0]     reg_watch_num,
   output logic [ADDR_W-1:0]        mem_watch_addr,
   output logic [DATA_W-1:0]        disp_data,
   output logic                     disp_valid,
   output logic                     sel_err
);

   localparam logic [1:0] MODE_RUN  = 2'b00;
   localparam logic [1:0] MODE_STEP = 2'b10;

   // Counter bits above the highest tap can never influence the taps, so the
   // counter stops there; its low bits follow a DIV_W free-running counter exactly.
   localparam int TAP_MAX = (TAP_SLOW > TAP_FAST) ? TAP_SLOW : TAP_FAST;
   localparam int CNT_W   = (TAP_MAX + 1 < DIV_W) ? TAP_MAX + 1 : DIV_W;

   logic [CNT_W-1:0]     div_q, div_d;
   logic                 slow_s1_q, slow_sel_q, slow_prev_q, tap_prev_q;
   logic                 btn_s1_q, btn_s2_q, btn_s3_q;
   logic [1:0]           settle_q, settle_d;
   logic                 step_pulse_q, step_pulse_d;
   logic [REG_NUM_W-1:0] reg_q, reg_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [ADDR_W:0]      addr_sum;
   logic [DATA_W-1:0]    disp_q, disp_d;
   logic                 disp_valid_q, disp_valid_d;
   logic                 sel_err_q, sel_err_d;
   logic                 tap_now, rate_switch, tick_w, adv, one_hot;

   // Rate tap, tick edge detect (suppressed in the rate-switch cycle), step edge and advance qualifier.
   // The button edge detector stays disarmed until the sync chain holds real samples,
   // so a button already held at reset release is not seen as a press.
   always_comb begin
      div_d        = div_q + CNT_W'(1);
      tap_now      = slow_sel_q ? div_q[TAP_SLOW] : div_q[TAP_FAST];
      rate_switch  = slow_sel_q ^ slow_prev_q;
      tick_w       = tap_now & ~tap_prev_q & ~rate_switch;
      settle_d     = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
      step_pulse_d = (settle_q == 2'd3) & btn_s2_q & ~btn_s3_q;
      adv          = ((mode == MODE_RUN) & tick_w) | ((mode == MODE_STEP) & step_pulse_q);
   end

   // Register index and memory address walkers; the address sum carries an extra bit so overflow wraps.
   always_comb begin
      reg_d    = reg_q;
      addr_d   = addr_q;
      addr_sum = {1'b0, addr_q} + (ADDR_W + 1)'(MEM_STRIDE);
      if (adv) begin
         reg_d  = (reg_q == REG_NUM_W'(REG_COUNT - 1)) ? '0 : reg_q + REG_NUM_W'(1);
         addr_d = (addr_sum >= (ADDR_W + 1)'(MEM_LIMIT)) ? '0 : addr_sum[ADDR_W-1:0];
      end
   end

   // Channel select: a one-hot select passes its slice, anything else shows zero and flags an error.
   always_comb begin
      one_hot = (ch_sel != '0) && ((ch_sel & (ch_sel - NUM_CH'(1))) == '0);
      disp_d  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (one_hot && ch_sel[i]) begin
            disp_d = ch_data[i*DATA_W +: DATA_W];
         end
      end
      sel_err_d    = ~one_hot;
      disp_valid_d = (disp_d != disp_q);
   end

   // State registers; everything clears immediately on reset, losing any step press in flight.
   always_ff @(posedge clk or negedge resetNeg) begin
      if (!resetNeg) begin
         div_q        <= '0;
         slow_s1_q    <= 1'b0;
         slow_sel_q   <= 1'b0;
         slow_prev_q  <= 1'b0;
         tap_prev_q   <= 1'b0;
         btn_s1_q     <= 1'b0;
         btn_s2_q     <= 1'b0;
         btn_s3_q     <= 1'b0;
         settle_q     <= 2'd0;
         step_pulse_q <= 1'b0;
         reg_q        <= '0;
         addr_q       <= '0;
         disp_q       <= '0;
         disp_valid_q <= 1'b0;
         sel_err_q    <= 1'b0;
      end else begin
         div_q        <= div_d;
         slow_s1_q    <= slow_sel;
         slow_sel_q   <= slow_s1_q;
         slow_prev_q  <= slow_sel_q;
         tap_prev_q   <= tap_now;
         btn_s1_q     <= step_btn;
         btn_s2_q     <= btn_s1_q;
         btn_s3_q     <= btn_s2_q;
         settle_q     <= settle_d;
         step_pulse_q <= step_pulse_d;
         reg_q        <= reg_d;
         addr_q       <= addr_d;
         disp_q       <= disp_d;
         disp_valid_q <= disp_valid_d;
         sel_err_q    <= sel_err_d;
      end
   end

   assign tick           = tick_w;
   assign reg_watch_num  = reg_q;
   assign mem_watch_addr = addr_q;
   assign disp_data      = disp_q;
   assign disp_valid     = disp_valid_q;
   assign sel_err        = sel_err_q;

endmodule

// File: tb/tb_debug_watch_scanner.sv
// tb/tb_debug_watch_scanner.sv - randomized self-checking bench for debug_watch_scanner
module tb_debug_watch_scanner;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 32;
   localparam int REG_NUM_W  = 5;
   localparam int REG_COUNT  = 4;
   localparam int NUM_CH     = 4;
   localparam int DIV_W      = 32;
   localparam int TAP_FAST   = 2;
   localparam int TAP_SLOW   = 4;
   localparam int MEM_STRIDE = 4;
   localparam int MEM_LIMIT  = 16;
   localparam int HIST       = 4096;

   logic                     clk = 1'b0;
   logic                     resetNeg;
   logic                     slow_sel;
   logic [1:0]               mode;
   logic                     step_btn;
   logic [NUM_CH-1:0]        ch_sel;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic                     tick;
   logic [REG_NUM_W-1:0]     reg_watch_num;
   logic [ADDR_W-1:0]        mem_watch_addr;
   logic [DATA_W-1:0]        disp_data;
   logic                     disp_valid;
   logic                     sel_err;

   debug_watch_scanner #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_NUM_W(REG_NUM_W), .REG_COUNT(REG_COUNT),
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .TAP_FAST(TAP_FAST), .TAP_SLOW(TAP_SLOW),
      .MEM_STRIDE(MEM_STRIDE), .MEM_LIMIT(MEM_LIMIT)
   ) dut (
      .clk(clk), .resetNeg(resetNeg), .slow_sel(slow_sel), .mode(mode), .step_btn(step_btn),
      .ch_sel(ch_sel), .ch_data(ch_data), .tick(tick), .reg_watch_num(reg_watch_num),
      .mem_watch_addr(mem_watch_addr), .disp_data(disp_data), .disp_valid(disp_valid),
      .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: n counts clock edges since reset release, so the divider value is n.
   int              n;
   bit              slow_h [HIST];
   bit              btn_h  [HIST];
   int              m_reg, m_addr;
   logic [DATA_W-1:0] m_disp;
   bit              m_valid, m_err;
   bit              exp_tick, exp_pulse;

   // Synchronised rate select seen in cycle k: the input applied two cycles earlier.
   function automatic bit slowq(input int k);
      return (k >= 2) ? slow_h[k-2] : 1'b0;
   endfunction

   function automatic bit tapv(input int k);
      if (k < 0) return 1'b0;
      return ((k >> (slowq(k) ? TAP_SLOW : TAP_FAST)) & 1) != 0;
   endfunction

   // Record this cycle's inputs, derive expected tick/step, then wait to mid-cycle.
   task automatic observe();
      if (n >= HIST) begin
         $display("FAIL history_overflow n=%0d limit=%0d", n, HIST);
         $fatal(1);
      end
      slow_h[n] = slow_sel;
      btn_h[n]  = step_btn;
      exp_tick  = tapv(n) && !tapv(n-1) && (slowq(n) == slowq(n-1));
      exp_pulse = (n >= 4) && btn_h[n-3] && !btn_h[n-4];
      @(negedge clk);
   endtask

   // Apply the clock edge to the model and the DUT.
   task automatic advance();
      bit adv;
      int ones;
      logic [DATA_W-1:0] nd;
      adv = (mode == 2'b00 && exp_tick) || (mode == 2'b10 && exp_pulse);
      if (adv) begin
         m_reg  = (m_reg + 1) % REG_COUNT;
         m_addr = (m_addr + MEM_STRIDE >= MEM_LIMIT) ? 0 : m_addr + MEM_STRIDE;
      end
      ones = $countones(ch_sel);
      nd = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (ones == 1 && ch_sel[i]) nd = ch_data[i*DATA_W +: DATA_W];
      m_valid = (nd != m_disp);
      m_disp  = nd;
      m_err   = (ones != 1);
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic do_reset(input bit btn_lvl);
      resetNeg = 1'b0;
      slow_sel = 1'b0; mode = 2'b01; step_btn = btn_lvl; ch_sel = '0; ch_data = '0;
      repeat (2) @(posedge clk);
      #1 resetNeg = 1'b1;
      n = 0; m_reg = 0; m_addr = 0; m_disp = '0; m_valid = 1'b0; m_err = 1'b0;
   endtask

   task automatic test_reset();
      #1 resetNeg = 1'b0;
      #2;
      vectors++;
      if ({tick, disp_valid, sel_err, reg_watch_num, mem_watch_addr, disp_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_hold got reg=%0d addr=%0d disp=%h v=%b e=%b t=%b want all 0",
                  reg_watch_num, mem_watch_addr, disp_data, disp_valid, sel_err, tick);
      end
      do_reset(1'b0);
      observe();
      vectors++;
      if ({tick, disp_valid, sel_err, reg_watch_num, mem_watch_addr, disp_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_release got reg=%0d addr=%0d disp=%h v=%b e=%b t=%b want all 0",
                  reg_watch_num, mem_watch_addr, disp_data, disp_valid, sel_err, tick);
      end
      advance();
   endtask

   task automatic test_run_fast();
      int ticks = 0;
      do_reset(1'b0);
      mode = 2'b00;
      for (int i = 0; i < 40; i++) begin
         observe();
         vectors++;
         if (tick !== exp_tick) begin
            miscompares++;
            $display("FAIL run_tick n=%0d got %b want %b", n, tick, exp_tick);
         end
         vectors++;
         if (reg_watch_num !== REG_NUM_W'(m_reg) || mem_watch_addr !== ADDR_W'(m_addr)) begin
            miscompares++;
            $display("FAIL run_walk n=%0d got reg=%0d addr=%0d want reg=%0d addr=%0d",
                     n, reg_watch_num, mem_watch_addr, m_reg, m_addr);
         end
         if (tick === 1'b1) ticks++;
         advance();
      end
      observe();
      vectors++;
      if (ticks != 5 || reg_watch_num !== 5'd1 || mem_watch_addr !== 32'd4) begin
         miscompares++;
         $display("FAIL run_wrap got ticks=%0d reg=%0d addr=%0d want ticks=5 reg=1 addr=4",
                  ticks, reg_watch_num, mem_watch_addr);
      end
      advance();
   endtask

   task automatic test_rate_switch();
      int ticks = 0;
      do_reset(1'b0);
      mode = 2'b00;
      for (int i = 0; i < 121; i++) begin
         slow_sel = (i >= 15);
         observe();
         vectors++;
         if (tick !== exp_tick) begin
            miscompares++;
            $display("FAIL rate_tick n=%0d got %b want %b", n, tick, exp_tick);
         end
         if (n == 17) begin
            vectors++;
            if (tick !== 1'b0) begin
               miscompares++;
               $display("FAIL rate_switch_cycle n=%0d got tick=%b want 0", n, tick);
            end
         end
         if (n >= 17 && tick === 1'b1) ticks++;
         advance();
      end
      vectors++;
      if (ticks != 3) begin
         miscompares++;
         $display("FAIL rate_slow_count got %0d ticks want 3", ticks);
      end
   endtask

   task automatic test_step();
      int moved = -1;
      do_reset(1'b0);
      mode = 2'b10;
      for (int i = 0; i < 80; i++) begin
         step_btn = (i >= 10 && i < 60);
         observe();
         vectors++;
         if (reg_watch_num !== REG_NUM_W'(m_reg) || mem_watch_addr !== ADDR_W'(m_addr)) begin
            miscompares++;
            $display("FAIL step_walk n=%0d got reg=%0d addr=%0d want reg=%0d addr=%0d",
                     n, reg_watch_num, mem_watch_addr, m_reg, m_addr);
         end
         if (reg_watch_num === 5'd1 && moved < 0) moved = n;
         advance();
      end
      observe();
      vectors++;
      if (moved != 14 || reg_watch_num !== 5'd1 || mem_watch_addr !== 32'd4) begin
         miscompares++;
         $display("FAIL step_once got moved_at=%0d reg=%0d addr=%0d want moved_at=14 reg=1 addr=4",
                  moved, reg_watch_num, mem_watch_addr);
      end
      advance();
   endtask

   task automatic test_hold();
      int ticks = 0;
      for (int i = 0; i < 100; i++) begin
         mode = ((i / 25) % 2 == 0) ? 2'b01 : 2'b11;
         step_btn = ((i % 10) >= 5);
         observe();
         vectors++;
         if (reg_watch_num !== 5'd1 || mem_watch_addr !== 32'd4 || tick !== exp_tick) begin
            miscompares++;
            $display("FAIL hold n=%0d got reg=%0d addr=%0d tick=%b want reg=1 addr=4 tick=%b",
                     n, reg_watch_num, mem_watch_addr, tick, exp_tick);
         end
         if (tick === 1'b1) ticks++;
         advance();
      end
      step_btn = 1'b0;
      vectors++;
      if (ticks < 10) begin
         miscompares++;
         $display("FAIL hold_ticks got %0d ticks want at least 10", ticks);
      end
   endtask

   task automatic test_display();
      logic [DATA_W-1:0] s0;
      observe();
      ch_data = {$urandom, $urandom, $urandom, $urandom};
      ch_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
      ch_sel = 4'b0100;
      advance();
      observe();
      vectors++;
      if (disp_data !== 32'hDEADBEEF || disp_valid !== 1'b1 || sel_err !== 1'b0) begin
         miscompares++;
         $display("FAIL disp_onehot got %h v=%b e=%b want deadbeef v=1 e=0", disp_data, disp_valid, sel_err);
      end
      ch_sel = 4'b0110;
      advance();
      observe();
      vectors++;
      if (disp_data !== '0 || disp_valid !== 1'b1 || sel_err !== 1'b1) begin
         miscompares++;
         $display("FAIL disp_multihot got %h v=%b e=%b want 0 v=1 e=1", disp_data, disp_valid, sel_err);
      end
      ch_sel = 4'b0000;
      advance();
      observe();
      vectors++;
      if (disp_data !== '0 || disp_valid !== 1'b0 || sel_err !== 1'b1) begin
         miscompares++;
         $display("FAIL disp_zero got %h v=%b e=%b want 0 v=0 e=1", disp_data, disp_valid, sel_err);
      end
      ch_data[0 +: DATA_W] = $urandom | 32'h1;
      s0 = ch_data[0 +: DATA_W];
      ch_sel = 4'b0001;
      advance();
      observe();
      vectors++;
      if (disp_data !== s0 || disp_valid !== 1'b1 || sel_err !== 1'b0) begin
         miscompares++;
         $display("FAIL disp_ch0 got %h v=%b e=%b want %h v=1 e=0", disp_data, disp_valid, sel_err, s0);
      end
      advance();
   endtask

   task automatic test_press_at_reset();
      do_reset(1'b1);
      mode = 2'b10;
      for (int i = 0; i < 40; i++) begin
         step_btn = (i < 20) || (i >= 25);
         observe();
         vectors++;
         if (reg_watch_num !== REG_NUM_W'(m_reg) || (i < 29 && reg_watch_num !== 5'd0)) begin
            miscompares++;
            $display("FAIL press_at_reset n=%0d got reg=%0d want %0d", n, reg_watch_num, m_reg);
         end
         advance();
      end
      vectors++;
      if (reg_watch_num !== 5'd1) begin
         miscompares++;
         $display("FAIL press_after_release got reg=%0d want 1", reg_watch_num);
      end
      step_btn = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset(1'b0);
      mode = 2'b00;
      ch_sel = 4'b0001;
      ch_data = {$urandom, $urandom, $urandom, $urandom | 32'h1};
      while (n < 16) begin
         observe();
         advance();
      end
      observe();
      vectors++;
      if (reg_watch_num !== 5'd2 || mem_watch_addr !== 32'd8 || disp_data === '0) begin
         miscompares++;
         $display("FAIL async_pre got reg=%0d addr=%0d disp=%h want reg=2 addr=8 disp!=0",
                  reg_watch_num, mem_watch_addr, disp_data);
      end
      #2 resetNeg = 1'b0;
      #1;
      vectors++;
      if ({tick, disp_valid, sel_err, reg_watch_num, mem_watch_addr, disp_data} !== '0) begin
         miscompares++;
         $display("FAIL async_reset got reg=%0d addr=%0d disp=%h v=%b e=%b t=%b want all 0",
                  reg_watch_num, mem_watch_addr, disp_data, disp_valid, sel_err, tick);
      end
      do_reset(1'b0);
   endtask

   task automatic test_random();
      do_reset(1'b0);
      mode = 2'b00;
      ch_sel = 4'b0001;
      ch_data = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(63) == 0) mode = 2'($urandom_range(3));
         if ($urandom_range(199) == 0) slow_sel = ~slow_sel;
         if ($urandom_range(5) == 0) step_btn = ~step_btn;
         if ($urandom_range(3) == 0) begin
            if ($urandom_range(5) == 0) ch_sel = 4'($urandom_range(15));
            else ch_sel = 4'b0001 << $urandom_range(3);
         end
         if ($urandom_range(7) == 0) ch_data[$urandom_range(3)*DATA_W +: DATA_W] = $urandom;
         observe();
         vectors++;
         if (tick !== exp_tick) begin
            miscompares++;
            $display("FAIL rnd_tick n=%0d got %b want %b", n, tick, exp_tick);
         end
         vectors++;
         if (reg_watch_num !== REG_NUM_W'(m_reg) || mem_watch_addr !== ADDR_W'(m_addr)) begin
            miscompares++;
            $display("FAIL rnd_walk n=%0d got reg=%0d addr=%0d want reg=%0d addr=%0d",
                     n, reg_watch_num, mem_watch_addr, m_reg, m_addr);
         end
         vectors++;
         if (disp_data !== m_disp || disp_valid !== m_valid || sel_err !== m_err) begin
            miscompares++;
            $display("FAIL rnd_disp n=%0d got %h v=%b e=%b want %h v=%b e=%b",
                     n, disp_data, disp_valid, sel_err, m_disp, m_valid, m_err);
         end
         advance();
      end
   endtask

   initial begin
      resetNeg = 1'b1;
      slow_sel = 1'b0; mode = 2'b01; step_btn = 1'b0; ch_sel = '0; ch_data = '0;
      n = 0;
      test_reset();
      test_run_fast();
      test_rate_switch();
      test_step();
      test_hold();
      test_display();
      test_press_at_reset();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
